muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit with architectural HI/LO registers. It sits beside the combinational ALU in the execute stage and services MULT, MULTU, DIV, DIVU, MTHI and MTLO. It is multi-cycle, so it uses a valid/ready handshake and a pipeline flush input for exceptions. The ALU has no state, no multi-cycle ops and a fixed 32-bit width; this unit adds all three.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; must be at least 4.
CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
op_valid  in  1  request present this cycle
op_ready  out  1  unit can accept a request (high only in IDLE)
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others ignored
src_a  in  WIDTH  multiplicand / dividend / MTxx data
src_b  in  WIDTH  multiplier / divisor
flush  in  1  abort in-flight op (exception or branch squash)
busy  out  1  CALC or FIN state
done  out  1  one-cycle pulse: HI/LO just updated by a mul/div
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE, hi=0, lo=0, done=0, counter=0, internal operands cleared. op_ready=1 and busy=0 after reset.
- Accept: op_valid && op_ready && !flush at a rising edge. Unknown op codes are dropped with no state change.
- MTHI/MTLO: write src_a to hi/lo at the accept edge. State stays IDLE and done is not pulsed. The new value is visible the next cycle.
- Mul/div accept: latch the operand magnitudes (abs values for signed ops) and result-sign flags, then go to CALC with counter=0.
- CALC, multiply: radix-2 shift-add, one bit per cycle, 2*WIDTH-bit product accumulator.
- CALC, divide: radix-2 restoring division, one quotient bit per cycle.
- CALC exit: after WIDTH cycles (counter==WIDTH-1) go to FIN.
- FIN (1 cycle): apply sign correction.
  - Signed mul: negate the product if the operand signs differ.
  - Signed div: quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
  - At the edge leaving FIN: {hi,lo} = product for mul; lo = quotient, hi = remainder for div. done=1 for exactly the next cycle. State=IDLE.
- Latency: accept edge to hi/lo update is WIDTH+1 edges. done is high in the cycle after the update. A new op may be accepted in that same done cycle.
- Divide by zero (divisor 0): lo = all ones, hi = src_a (unsigned and signed). Normal latency; no exception raised here.
- Signed overflow (min_int / -1): lo = min_int, hi = 0.
- Flush:
  - In CALC or FIN: next edge returns to IDLE; hi/lo unchanged; no done pulse.
  - Flush beats FIN completion in the same cycle.
  - Flush during IDLE blocks acceptance of a simultaneous op, including MTHI/MTLO.
- A new op_valid while busy is ignored (op_ready=0); the requester holds op_valid until accepted.
- Reset mid-operation aborts immediately and clears hi/lo.
- The counter never wraps: it is cleared on every accept.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings MD_MULT..MD_MTLO
  - state encoding IDLE/CALC/FIN
- One natural sub-module: muldiv_iter_core.
  - Holds the unsigned shift-add / restoring-division datapath and the counter.
  - Start/done interface to the top-level FSM.
  - Sign handling and HI/LO live in muldiv_unit.

Test Plan:
- MULT a=0xFFFFFFFE, b=3 -> after 33 edges hi=0xFFFFFFFF, lo=0xFFFFFFFA; done high exactly one cycle; op_ready low throughout CALC/FIN.
- MULTU a=0xFFFFFFFE, b=3 -> hi=0x00000002, lo=0xFFFFFFFA. Then back-to-back DIV a=0xFFFFFFF9 (-7), b=2 accepted in the done cycle -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=0x00000007. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI src_a=0x12345678, then MTLO src_a=0x9ABCDEF0 on consecutive cycles -> hi/lo updated one cycle after each accept; done never pulses. Then flush asserted 10 cycles into a MULT -> IDLE next edge, hi/lo keep 0x12345678/0x9ABCDEF0, no done.
- Deassert resetn asynchronously mid-DIV (no clock edge) -> hi=lo=0, busy=0, op_ready=1 immediately.
- WIDTH=8 instance: MULT 0x80 * 0x80 -> hi=0x40, lo=0x00 after 9 edges. Random signed/unsigned mul/div vs. reference model, 10k ops.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  // Operation codes presented on the op bus
  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIN  = 2'b10
  } md_state_e;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the mul/div unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic             op_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, op, src_a, src_b, flush,
    input  op_ready, busy, done, hi, lo
  );

  modport slave (
    input  op_valid, op, src_a, src_b, flush,
    output op_ready, busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_iter_core.sv
// Unsigned radix-2 datapath: shift-add multiply and restoring divide.
// One shared 2*WIDTH accumulator: upper half is partial product / remainder,
// lower half is the multiplier / dividend being shifted out and replaced by
// product bits / quotient bits.
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               run,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  output logic               last,
  output logic [2*WIDTH-1:0] acc
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   opb_r;
  logic               is_div_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [WIDTH:0]       add_s;
  logic [WIDTH:0]       shl_s;
  logic [WIDTH-1:0]     diff_s;
  logic                 ge_s;
  logic [2*WIDTH-1:0]   step_s;

  // One iteration of either algorithm, selected by the latched op kind
  always_comb begin
    add_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
             (acc_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
    shl_s  = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    ge_s   = (shl_s >= {1'b0, opb_r});
    diff_s = shl_s[WIDTH-1:0] - opb_r;
    if (is_div_r) begin
      if (ge_s) begin
        step_s = {diff_s, acc_r[WIDTH-2:0], 1'b1};
      end else begin
        step_s = {shl_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_s = {add_s, acc_r[WIDTH-1:1]};
    end
  end

  // Operand load on start, one iteration per cycle while running
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_r    <= {(2*WIDTH){1'b0}};
      opb_r    <= {WIDTH{1'b0}};
      is_div_r <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else if (start) begin
      acc_r    <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
      opb_r    <= is_div ? b_mag : a_mag;
      is_div_r <= is_div;
      cnt_r    <= {CNT_W{1'b0}};
    end else if (run) begin
      acc_r    <= step_s;
      cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      acc_r    <= acc_r;
      cnt_r    <= cnt_r;
    end
  end

  assign last = (cnt_r == CNT_W'(WIDTH - 1));
  assign acc  = acc_r;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Operands are reduced to magnitudes on accept; signs are re-applied in FIN.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     resetn,
  muldiv_if.slave  bus
);
  md_state_e        state_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             done_r;
  logic             ready_r;
  logic             busy_r;
  logic             neg_res_r;
  logic             neg_rem_r;
  logic             div0_r;
  logic             is_div_r;

  logic               accept_s;
  logic               start_s;
  logic               run_s;
  logic               sgn_op_s;
  logic               div_op_s;
  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic               last_s;
  logic [2*WIDTH-1:0] acc_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   rem_s;

  // Request decode and operand magnitudes
  always_comb begin
    accept_s = bus.op_valid && ready_r && !bus.flush;
    start_s  = accept_s && (bus.op[2] == 1'b0);
    run_s    = (state_r == CALC);
    sgn_op_s = (bus.op == MD_MULT) || (bus.op == MD_DIV);
    div_op_s = bus.op[1];
    a_neg_s  = sgn_op_s && bus.src_a[WIDTH-1];
    b_neg_s  = sgn_op_s && bus.src_b[WIDTH-1];
    a_mag_s  = a_neg_s ? -bus.src_a : bus.src_a;
    b_mag_s  = b_neg_s ? -bus.src_b : bus.src_b;
  end

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .resetn (resetn),
    .start  (start_s),
    .run    (run_s),
    .is_div (div_op_s),
    .a_mag  (a_mag_s),
    .b_mag  (b_mag_s),
    .last   (last_s),
    .acc    (acc_s)
  );

  // Sign correction of the unsigned core result; divide-by-zero forces LO
  always_comb begin
    prod_s = neg_res_r ? -acc_s : acc_s;
    if (div0_r) begin
      quot_s = {WIDTH{1'b1}};
    end else if (neg_res_r) begin
      quot_s = -acc_s[WIDTH-1:0];
    end else begin
      quot_s = acc_s[WIDTH-1:0];
    end
    if (neg_rem_r) begin
      rem_s = -acc_s[2*WIDTH-1:WIDTH];
    end else begin
      rem_s = acc_s[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM owning HI/LO, status outputs and latched sign flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= IDLE;
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      done_r    <= 1'b0;
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      div0_r    <= 1'b0;
      is_div_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            case (bus.op)
              MD_MTHI: hi_r <= bus.src_a;
              MD_MTLO: lo_r <= bus.src_a;
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                neg_res_r <= a_neg_s ^ b_neg_s;
                neg_rem_r <= a_neg_s;
                div0_r    <= div_op_s && (bus.src_b == {WIDTH{1'b0}});
                is_div_r  <= div_op_s;
                state_r   <= CALC;
                ready_r   <= 1'b0;
                busy_r    <= 1'b1;
              end
              default: begin
                state_r <= IDLE;
              end
            endcase
          end
        end
        CALC: begin
          if (bus.flush) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
          end else if (last_s) begin
            state_r <= FIN;
          end
        end
        FIN: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          if (!bus.flush) begin
            done_r <= 1'b1;
            if (is_div_r) begin
              hi_r <= rem_s;
              lo_r <= quot_s;
            end else begin
              hi_r <= prod_s[2*WIDTH-1:WIDTH];
              lo_r <= prod_s[WIDTH-1:0];
            end
          end
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.op_ready = ready_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;

endmodule
